// File: rtl/aes_top_pack.sv
// Shared types and constants for the MAC reply framer.
// MAC_REPLY_PAD_EN adds the PAD state used to stretch short frames.
package aes_top_pack;

  localparam int unsigned MAC_ADDR_WIDTH  = 48;
  localparam int unsigned ETHERTYPE_WIDTH = 16;

  // Field offsets inside the 112-bit received header.
  localparam int unsigned HDR_DST_LSB = 64;
  localparam int unsigned HDR_SRC_LSB = 16;
  localparam int unsigned HDR_ETH_LSB = 0;

  localparam int unsigned BYTE_CNT_WIDTH = 11;
  localparam logic [BYTE_CNT_WIDTH-1:0] BYTE_CNT_MAX = '1;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
`ifdef MAC_REPLY_PAD_EN
    StPay,
    StPad
`else
    StPay
`endif
  } framer_state_e;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST style stream bundle (data/valid/ready/sop/eop), ready latency 0.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;

  modport source (output data, output valid, output sop, output eop, input ready);
  modport sink   (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/mac_hdr_serializer.sv
// Header shift register (MSB byte first) plus saturating count of emitted frame bytes.
module mac_hdr_serializer
  import aes_top_pack::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned HEADER_SIZE = 112
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [HEADER_SIZE-1:0]    hdr_in,
  input  logic                      advance,
  output logic [DATA_WIDTH-1:0]     hdr_byte,
  output logic [BYTE_CNT_WIDTH-1:0] byte_cnt
);

  logic [HEADER_SIZE-1:0]    shift_q;
  logic [BYTE_CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= hdr_in;
      cnt_q   <= '0;
    end else if (advance) begin
      shift_q <= shift_q << DATA_WIDTH;
      if (cnt_q != BYTE_CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign hdr_byte = shift_q[HEADER_SIZE-1 -: DATA_WIDTH];
  assign byte_cnt = cnt_q;

endmodule

// File: rtl/mac_reply_framer.sv
// Builds an Ethernet reply header (dst/src swapped, own SRC_MAC) and prepends it to a payload.
// MAC_REPLY_PAD_EN: zero-pad frames shorter than MIN_FRAME_BYTES.
module mac_reply_framer
  import aes_top_pack::*;
#(
  parameter int unsigned                DATA_WIDTH      = 8,
  parameter int unsigned                HEADER_SIZE     = 112,
  parameter logic [MAC_ADDR_WIDTH-1:0]  SRC_MAC         = 48'h001C24174ACB,
  parameter int unsigned                MIN_FRAME_BYTES = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HEADER_SIZE-1:0] hdr_data,
  input  logic                   hdr_valid,
  output logic                   hdr_ready,
  output logic                   hdr_drop,
  avalon_st_if.sink              payload_in,
  avalon_st_if.source            frame_out
);

  localparam logic [BYTE_CNT_WIDTH-1:0] HdrLast = BYTE_CNT_WIDTH'(HEADER_SIZE / DATA_WIDTH - 1);

  framer_state_e             state_q, state_d;
  logic [HEADER_SIZE-1:0]    held_q;
  logic                      full_q, full_d;
  logic                      drop_q, drop_d;
  logic [HEADER_SIZE-1:0]    reply_hdr;
  logic                      hdr_accept;
  logic                      load;
  logic                      advance;
  logic [DATA_WIDTH-1:0]     hdr_byte;
  logic [BYTE_CNT_WIDTH-1:0] byte_cnt;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sop;
  logic                  out_eop;
  logic                  pay_ready;

  logic unused_dst;
  assign unused_dst = ^hdr_data[HDR_DST_LSB +: MAC_ADDR_WIDTH];

  assign reply_hdr = {hdr_data[HDR_SRC_LSB +: MAC_ADDR_WIDTH], SRC_MAC,
                      hdr_data[HDR_ETH_LSB +: ETHERTYPE_WIDTH]};

`ifdef MAC_REPLY_PAD_EN
  localparam logic [BYTE_CNT_WIDTH-1:0] MinCnt = BYTE_CNT_WIDTH'(MIN_FRAME_BYTES);
  logic [BYTE_CNT_WIDTH-1:0] byte_cnt_inc;
  // Count including the beat currently on the output.
  assign byte_cnt_inc = (byte_cnt == BYTE_CNT_MAX) ? byte_cnt : byte_cnt + 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    pay_ready = 1'b0;
    load      = 1'b0;
    case (state_q)
      StIdle: begin
        if (payload_in.valid && payload_in.sop) begin
          // The sop beat is held back and forwarded as the first payload beat.
          if (full_q) begin
            load    = 1'b1;
            state_d = StHdr;
          end
        end else begin
          pay_ready = payload_in.valid;
        end
      end
      StHdr: begin
        out_valid = 1'b1;
        out_data  = hdr_byte;
        out_sop   = (byte_cnt == '0);
        if (frame_out.ready && byte_cnt == HdrLast) begin
          state_d = StPay;
        end
      end
      StPay: begin
        out_valid = payload_in.valid;
        out_data  = payload_in.data;
        pay_ready = frame_out.ready;
`ifdef MAC_REPLY_PAD_EN
        out_eop = payload_in.eop && (byte_cnt_inc >= MinCnt);
        if (payload_in.valid && frame_out.ready && payload_in.eop) begin
          state_d = out_eop ? StIdle : StPad;
        end
`else
        out_eop = payload_in.eop;
        if (payload_in.valid && frame_out.ready && payload_in.eop) begin
          state_d = StIdle;
        end
`endif
      end
`ifdef MAC_REPLY_PAD_EN
      StPad: begin
        out_valid = 1'b1;
        out_eop   = (byte_cnt_inc >= MinCnt);
        if (frame_out.ready && out_eop) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // A header arriving while the register is being emptied takes the freed slot.
  assign hdr_accept = hdr_valid && (!full_q || load);
  assign drop_d     = hdr_valid && full_q && !load;
  assign full_d     = hdr_accept ? 1'b1 : (load ? 1'b0 : full_q);
  assign advance    = out_valid && frame_out.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
      if (hdr_accept) begin
        held_q <= reply_hdr;
      end
    end
  end

  mac_hdr_serializer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .HEADER_SIZE (HEADER_SIZE)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .hdr_in   (held_q),
    .advance  (advance),
    .hdr_byte (hdr_byte),
    .byte_cnt (byte_cnt)
  );

  assign hdr_ready        = !full_q;
  assign hdr_drop         = drop_q;
  assign frame_out.valid  = out_valid;
  assign frame_out.data   = out_data;
  assign frame_out.sop    = out_sop;
  assign frame_out.eop    = out_eop;
  assign payload_in.ready = pay_ready;

endmodule

// File: tb/tb_mac_reply_framer.sv
// Randomized bench for mac_reply_framer against a byte-list reference model.
// Expectations follow MAC_REPLY_PAD_EN when it is defined for the build.
module tb_mac_reply_framer;

  localparam logic [47:0] OWN_MAC   = 48'h001C24174ACB;
  localparam int          MIN_BYTES = 60;

  logic         clk = 1'b0;
  logic         rst;
  logic [111:0] hdr_data;
  logic         hdr_valid;
  logic         hdr_ready;
  logic         hdr_drop;

  avalon_st_if #(.DATA_WIDTH(8)) pay_if ();
  avalon_st_if #(.DATA_WIDTH(8)) out_if ();

  mac_reply_framer #(
    .DATA_WIDTH      (8),
    .HEADER_SIZE     (112),
    .SRC_MAC         (OWN_MAC),
    .MIN_FRAME_BYTES (MIN_BYTES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hdr_data   (hdr_data),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .hdr_drop   (hdr_drop),
    .payload_in (pay_if),
    .frame_out  (out_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [9:0] out_q[$];   // {sop, eop, data} per output handshake
  logic [9:0] exp_q[$];
  logic [7:0] pay_q[$];
  bit         eop_seen;
  int         drop_cnt;

  always @(negedge clk) begin
    if (!rst && out_if.valid && out_if.ready) begin
      out_q.push_back({out_if.sop, out_if.eop, out_if.data});
      if (out_if.eop) eop_seen = 1'b1;
    end
    if (!rst && hdr_drop) drop_cnt++;
  end

  function automatic logic [111:0] mk_hdr(input logic [47:0] dst, input logic [47:0] src,
                                          input logic [15:0] eth);
    return {dst, src, eth};
  endfunction

  // Reference frame: reply header bytes, payload bytes, optional zero pad to the minimum.
  task automatic build_expected(input logic [111:0] rx);
    logic [7:0]  bytes[$];
    logic [47:0] peer;
    logic [47:0] own;
    logic [15:0] eth;
    peer = rx[63:16];
    own  = OWN_MAC;
    eth  = rx[15:0];
    for (int i = 0; i < 6; i++) bytes.push_back(peer[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) bytes.push_back(own[47-8*i -: 8]);
    bytes.push_back(eth[15:8]);
    bytes.push_back(eth[7:0]);
    foreach (pay_q[i]) bytes.push_back(pay_q[i]);
`ifdef MAC_REPLY_PAD_EN
    while (bytes.size() < MIN_BYTES) bytes.push_back(8'h00);
`endif
    exp_q.delete();
    foreach (bytes[i]) exp_q.push_back({(i == 0), (i == bytes.size() - 1), bytes[i]});
  endtask

  // Index of the first differing beat, -1 when out_q equals exp_q exactly.
  function automatic int first_diff();
    int n;
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
    if (out_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic fill_payload(input int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic idle_inputs();
    hdr_valid    = 1'b0;
    hdr_data     = '0;
    pay_if.valid = 1'b0;
    pay_if.data  = '0;
    pay_if.sop   = 1'b0;
    pay_if.eop   = 1'b0;
    out_if.ready = 1'b1;
  endtask

  task automatic pulse_hdr(input logic [111:0] h);
    hdr_data  = h;
    hdr_valid = 1'b1;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  // Streams pay_q with sop/eop; mode 0 ready=1, 1 toggling, 2 random. Stops after output eop.
  task automatic run_payload(input int mode, input bit gaps, input bit hdr_with_sop,
                             input logic [111:0] hdr2, input int max_cycles, output bit ok);
    int idx;
    bit vld;
    bit hs;
    idx = 0;
    ok  = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      vld = (idx < pay_q.size()) && (!gaps || $urandom_range(0, 3) != 0);
      pay_if.valid = vld;
      pay_if.data  = vld ? pay_q[idx] : 8'($urandom);
      pay_if.sop   = vld && (idx == 0);
      pay_if.eop   = vld && (idx == pay_q.size() - 1);
      out_if.ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      hdr_valid    = hdr_with_sop && (cyc == 0);
      hdr_data     = hdr2;
      @(negedge clk);
      hs = pay_if.valid && pay_if.ready;
      @(posedge clk); #1;
      hdr_valid = 1'b0;
      if (hs) idx++;
      if (eop_seen) begin
        ok = 1'b1;
        break;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (hdr_ready !== 1'b1) begin failures++; $display("FAIL reset_hdr_ready got=%b exp=1", hdr_ready); end
    checks++; if (hdr_drop !== 1'b0) begin failures++; $display("FAIL reset_hdr_drop got=%b exp=0", hdr_drop); end
    checks++; if (out_if.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_if.valid); end
    checks++; if (out_if.sop !== 1'b0) begin failures++; $display("FAIL reset_sop got=%b exp=0", out_if.sop); end
    checks++; if (out_if.eop !== 1'b0) begin failures++; $display("FAIL reset_eop got=%b exp=0", out_if.eop); end
    checks++; if (pay_if.ready !== 1'b0) begin failures++; $display("FAIL reset_pay_ready got=%b exp=0", pay_if.ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_100(input int mode, input string name);
    logic [111:0] h;
    bit ok;
    int d;
    h = mk_hdr(48'h020304050607, 48'hAABBCCDDEEFF, 16'h0800);
    fill_payload(100);
    out_q.delete(); eop_seen = 1'b0;
    pulse_hdr(h);
    build_expected(h);
    run_payload(mode, 1'b0, 1'b0, '0, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_done got=timeout exp=eop", name); end
    checks++; if (out_q.size() !== 114) begin failures++; $display("FAIL %s_len got=%0d exp=114", name, out_q.size()); end
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL %s_frame beat=%0d got=%h exp=%h", name, d, (d < out_q.size()) ? out_q[d] : 10'h3ff, (d < exp_q.size()) ? exp_q[d] : 10'h3ff); end
    if (out_q.size() == 114) begin
      checks++; if (out_q[0] !== 10'h2AA) begin failures++; $display("FAIL %s_beat0 got=%h exp=2aa", name, out_q[0]); end
      checks++; if (out_q[5][7:0] !== 8'hFF) begin failures++; $display("FAIL %s_beat5 got=%h exp=ff", name, out_q[5][7:0]); end
      checks++; if (out_q[6][7:0] !== 8'h00) begin failures++; $display("FAIL %s_beat6 got=%h exp=00", name, out_q[6][7:0]); end
      checks++; if (out_q[11][7:0] !== 8'hCB) begin failures++; $display("FAIL %s_beat11 got=%h exp=cb", name, out_q[11][7:0]); end
      checks++; if (out_q[12][7:0] !== 8'h08) begin failures++; $display("FAIL %s_beat12 got=%h exp=08", name, out_q[12][7:0]); end
      checks++; if (out_q[113][8] !== 1'b1) begin failures++; $display("FAIL %s_eop113 got=%b exp=1", name, out_q[113][8]); end
    end
  endtask

  task automatic test_short_pad();
    logic [111:0] h;
    bit ok;
    int d;
    int exp_len;
`ifdef MAC_REPLY_PAD_EN
    exp_len = 60;
`else
    exp_len = 24;
`endif
    h = mk_hdr(48'h111111111111, 48'h123456789ABC, 16'h86DD);
    fill_payload(10);
    out_q.delete(); eop_seen = 1'b0;
    pulse_hdr(h);
    build_expected(h);
    run_payload(0, 1'b0, 1'b0, '0, 500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL short_done got=timeout exp=eop"); end
    checks++; if (out_q.size() !== exp_len) begin failures++; $display("FAIL short_len got=%0d exp=%0d", out_q.size(), exp_len); end
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL short_frame beat=%0d got=%h exp=%h", d, (d < out_q.size()) ? out_q[d] : 10'h3ff, (d < exp_q.size()) ? exp_q[d] : 10'h3ff); end
  endtask

  task automatic test_hdr_drop();
    logic [111:0] ha;
    logic [111:0] hb;
    bit ok;
    int d;
    ha = mk_hdr(48'h0, 48'hA1A2A3A4A5A6, 16'h0806);
    hb = mk_hdr(48'h0, 48'hB1B2B3B4B5B6, 16'h0800);
    out_q.delete(); eop_seen = 1'b0;
    pulse_hdr(ha);
    checks++; if (hdr_drop !== 1'b0) begin failures++; $display("FAIL drop_first got=%b exp=0", hdr_drop); end
    checks++; if (hdr_ready !== 1'b0) begin failures++; $display("FAIL drop_ready_full got=%b exp=0", hdr_ready); end
    pulse_hdr(hb);
    checks++; if (hdr_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", hdr_drop); end
    @(posedge clk); #1;
    checks++; if (hdr_drop !== 1'b0) begin failures++; $display("FAIL drop_one_cycle got=%b exp=0", hdr_drop); end
    fill_payload($urandom_range(40, 60));
    build_expected(ha);
    run_payload(2, 1'b1, 1'b0, '0, 2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_done got=timeout exp=eop"); end
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL drop_frame beat=%0d got=%h exp=%h", d, (d < out_q.size()) ? out_q[d] : 10'h3ff, (d < exp_q.size()) ? exp_q[d] : 10'h3ff); end
  endtask

  task automatic test_idle_discard();
    out_q.delete();
    for (int k = 0; k < 3; k++) begin
      pay_if.valid = 1'b1;
      pay_if.sop   = 1'b0;
      pay_if.eop   = (k == 2);
      pay_if.data  = 8'($urandom);
      @(negedge clk);
      checks++; if (pay_if.ready !== 1'b1) begin failures++; $display("FAIL idle_ready beat=%0d got=%b exp=1", k, pay_if.ready); end
      checks++; if (out_if.valid !== 1'b0) begin failures++; $display("FAIL idle_valid beat=%0d got=%b exp=0", k, out_if.valid); end
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++; if (out_q.size() !== 0) begin failures++; $display("FAIL idle_output got=%0d exp=0", out_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [111:0] ha;
    logic [111:0] hb;
    bit ok;
    int d;
    ha = mk_hdr(48'h0, 48'hC0C1C2C3C4C5, 16'h1234);
    hb = mk_hdr(48'h0, 48'hD0D1D2D3D4D5, 16'h5678);
    drop_cnt = 0;
    out_q.delete(); eop_seen = 1'b0;
    pulse_hdr(ha);
    fill_payload(20);
    build_expected(ha);
    run_payload(0, 1'b0, 1'b1, hb, 500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_first_done got=timeout exp=eop"); end
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL b2b_first_frame beat=%0d got=%h exp=%h", d, (d < out_q.size()) ? out_q[d] : 10'h3ff, (d < exp_q.size()) ? exp_q[d] : 10'h3ff); end
    checks++; if (drop_cnt !== 0) begin failures++; $display("FAIL b2b_drop got=%0d exp=0", drop_cnt); end
    checks++; if (hdr_ready !== 1'b0) begin failures++; $display("FAIL b2b_held got=%b exp=0", hdr_ready); end
    out_q.delete(); eop_seen = 1'b0;
    fill_payload(70);
    build_expected(hb);
    run_payload(0, 1'b0, 1'b0, '0, 500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_second_done got=timeout exp=eop"); end
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL b2b_second_frame beat=%0d got=%h exp=%h", d, (d < out_q.size()) ? out_q[d] : 10'h3ff, (d < exp_q.size()) ? exp_q[d] : 10'h3ff); end
  endtask

  task automatic test_random();
    logic [111:0] h;
    bit ok;
    int d;
    for (int f = 0; f < 8; f++) begin
      h = {32'($urandom), 32'($urandom), 32'($urandom), 16'($urandom)};
      fill_payload($urandom_range(1, 80));
      out_q.delete(); eop_seen = 1'b0;
      pulse_hdr(h);
      build_expected(h);
      run_payload($urandom_range(0, 2), 1'b1, 1'b0, '0, 3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rand%0d_done got=timeout exp=eop", f); end
      d = first_diff();
      checks++; if (d !== -1) begin failures++; $display("FAIL rand%0d_frame beat=%0d got=%h exp=%h", f, d, (d < out_q.size()) ? out_q[d] : 10'h3ff, (d < exp_q.size()) ? exp_q[d] : 10'h3ff); end
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    out_q.delete(); eop_seen = 1'b0;
    fill_payload(30);
    pulse_hdr(mk_hdr(48'h0, 48'hE0E1E2E3E4E5, 16'h0800));
    pay_if.valid = 1'b1;
    pay_if.sop   = 1'b1;
    pay_if.eop   = 1'b0;
    pay_if.data  = pay_q[0];
    out_if.ready = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_q.size() >= 5) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached || out_q.size() !== 5) begin failures++; $display("FAIL midrst_reach got=%0d exp=5", out_q.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (out_if.valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_if.valid); end
    checks++; if (hdr_ready !== 1'b1) begin failures++; $display("FAIL midrst_hdr_ready got=%b exp=1", hdr_ready); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (eop_seen !== 1'b0) begin failures++; $display("FAIL midrst_eop got=%b exp=0", eop_seen); end
    checks++; if (out_q.size() !== 5) begin failures++; $display("FAIL midrst_beats got=%0d exp=5", out_q.size()); end
  endtask

  initial begin
    drop_cnt = 0;
    eop_seen = 1'b0;
    test_reset();
    test_basic_100(0, "ready1");
    test_basic_100(1, "toggle");
    test_short_pad();
    test_hdr_drop();
    test_idle_discard();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_reply_framer.md
MAC_REPLY_FRAMER -- requirements
Module: mac_reply_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, stream beat width in bits (one byte per beat).
REQ-002 SHALL have parameter HEADER_SIZE, default 112, MAC header width in bits.
REQ-003 SHALL have parameter SRC_MAC, default 48'h001C24174ACB, source MAC placed in every reply.
REQ-004 SHALL have parameter MIN_FRAME_BYTES, default 60, minimum emitted frame length, header included.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port hdr_data  input  HEADER_SIZE  received header: [111:64] dst, [63:16] src, [15:0] ethertype.
REQ-008 SHALL have port hdr_valid  input  1  one-cycle qualifier for hdr_data.
REQ-009 SHALL have port hdr_ready  output  1  header holding register is empty.
REQ-010 SHALL have port hdr_drop  output  1  one-cycle pulse when a header arrives while the holding register is full.
REQ-011 SHALL have port payload_in  avalon_st_if sink  DATA_WIDTH  payload stream (data, valid, ready, sop, eop).
REQ-012 SHALL have port frame_out  avalon_st_if source  DATA_WIDTH  framed reply stream, ready latency 0.

Function
REQ-013 SHALL compute the reply header as: dst = received src, src = SRC_MAC, ethertype = received ethertype.
REQ-014 SHALL capture the reply header into a one-entry holding register on hdr_valid when the register is empty.
REQ-015 SHALL pulse hdr_drop, discard the new header and keep the stored one when hdr_valid arrives with the register full.
REQ-016 SHALL run FSM IDLE -> HDR when the holding register is full and payload_in.valid and payload_in.sop are both high.
REQ-017 SHALL copy the header into a shift register and free the holding register in the same cycle as the IDLE->HDR transition.
REQ-018 SHALL in HDR drive frame_out.valid=1 with header bytes MSB first, 14 beats, sop on beat 0, advancing only on frame_out.ready.
REQ-019 SHALL in HDR hold payload_in.ready=0; HDR -> PAY after the beat-13 handshake.
REQ-020 SHALL in PAY pass through combinationally: frame_out.data/valid = payload_in.data/valid, payload_in.ready = frame_out.ready, sop=0.
REQ-021 SHALL ignore a payload sop seen in PAY and forward that beat as ordinary data.
REQ-022 SHALL count emitted bytes in an 11-bit counter, saturating at 2047.
REQ-023 SHALL on a payload eop handshake forward eop and go to IDLE when the count incl. that beat >= MIN_FRAME_BYTES; otherwise suppress eop and go to PAD.
REQ-024 SHALL in PAD emit zero bytes (payload_in.ready=0), with eop on the beat that makes the count equal MIN_FRAME_BYTES, then go to IDLE.
REQ-025 SHALL in IDLE accept and discard payload beats without sop (payload_in.ready=1), keeping frame_out.valid=0.
REQ-026 SHALL in IDLE hold payload_in.ready=0 for a sop beat while the holding register is empty.
REQ-027 SHALL accept a header arriving in the same cycle as IDLE->HDR into the register freed by REQ-017.

Reset
REQ-028 SHALL on rst go to IDLE, empty the holding register, clear counters, and drive frame_out.valid/sop/eop=0, payload_in.ready=0, hdr_drop=0, hdr_ready=1 from the next cycle.
REQ-029 SHALL on reset mid-frame truncate the frame without emitting eop.

Configuration
REQ-030 SHALL with MAC_REPLY_PAD_EN defined implement PAD as in REQ-023/024.
REQ-031 SHALL without MAC_REPLY_PAD_EN forward every payload eop directly and return to IDLE, with no PAD state.

Structure
REQ-032 SHALL place the FSM state enum, MAC_ADDR_WIDTH=48, ETHERTYPE_WIDTH=16 and the header field offsets in aes_top_pack.
REQ-033 SHALL implement the header shift register and beat counter as sub-module mac_hdr_serializer.

Verification
REQ-034 SHALL cover: header src=0xAABBCCDDEEFF, ethertype 0x0800, 100-byte payload, ready=1 -> 114 beats; dst bytes AA..FF; src 00 1C 24 17 4A CB; sop on beat 0; eop on beat 113.
REQ-035 SHALL cover: 10-byte payload with MAC_REPLY_PAD_EN -> 60 beats, bytes 24..59 equal 0, eop only on beat 59; same stimulus without the macro -> 24 beats.
REQ-036 SHALL cover: frame_out.ready toggled 1-0-1 every cycle -> byte sequence identical to the ready=1 case and no beat lost or duplicated.
REQ-037 SHALL cover: two hdr_valid pulses in IDLE before any payload -> second pulse sets hdr_drop=1 for one cycle; the reply uses the first header.
REQ-038 SHALL cover: 3 payload beats without sop in IDLE -> all consumed and frame_out.valid stays 0; rst asserted at header beat 5 -> valid=0 next cycle and no eop emitted.
